// File: rtl/mc_pad_ctrl_pkg.sv
// mc_pad_ctrl_pkg -- shared types and default sizing for the pad I/O controller.
// Holds the controller state enum and the default values of the top-level
// parameters so that the top, the synchronizer and any integrating block
// agree on them.

package mc_pad_ctrl_pkg;

    // Default width of the bidirectional pad bank.
    localparam int DefaultNumPads    = 8;

    // Default number of dead cycles inserted on every drive-direction change.
    localparam int DefaultTurnCycles = 2;

    // Default depth of the input synchronizer (only used when the synchronizer
    // is built in).
    localparam int DefaultSyncStages = 2;

    // Controller states.
    //   RX_IDLE : pads released, waiting for a request
    //   TX_IDLE : pads driven, waiting for a request
    //   TURN    : bus dead time while the drive direction changes
    //   SETTLE  : waiting for the synchronizer to flush a fresh pad value
    //   RESP    : read data presented until the consumer takes it
    typedef enum logic [2:0] {
        RX_IDLE = 3'd0,
        TX_IDLE = 3'd1,
        TURN    = 3'd2,
        SETTLE  = 3'd3,
        RESP    = 3'd4
    } padState_e;

endpackage : mc_pad_ctrl_pkg

// File: rtl/mc_pad_sync.sv
// mc_pad_sync -- multi-flop synchronizer for the asynchronous pad inputs.
// Every bit passes through Depth flops clocked by clk_i; the chain clears to
// zero under the synchronous active-high reset. Only instantiated by
// mc_pad_io_ctrl when MC_PAD_IO_CTRL_SYNC_EN is defined.

module mc_pad_sync #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage_q [Depth];

    // Shift the raw pad value down the chain one flop per clock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[Depth-1];

endmodule : mc_pad_sync

// File: rtl/mc_pad_io_ctrl.sv
// mc_pad_io_ctrl -- request/response controller for a bidirectional pad bank.
// A write drives req_data_i onto the pads, a read releases the pads and
// returns the sampled pad value on the response channel. Every change of
// drive direction inserts TurnCycles dead cycles with the output enable low.
//
// Build option: define MC_PAD_IO_CTRL_SYNC_EN to route pad_d_i through a
// SyncStages-deep synchronizer (mc_pad_sync) and wait in SETTLE for it to
// flush before capturing. Without the macro pad_d_i is captured directly,
// SETTLE is never entered and SyncStages has no effect on behaviour.

module mc_pad_io_ctrl
    import mc_pad_ctrl_pkg::*;
#(
    parameter int NumPads    = DefaultNumPads,
    parameter int TurnCycles = DefaultTurnCycles,
    parameter int SyncStages = DefaultSyncStages
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_write_i,
    input  logic [NumPads-1:0] req_data_i,

    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [NumPads-1:0] rsp_data_o,

    output logic [NumPads-1:0] pad_d_o,
    output logic               pad_oe_o,
    input  logic [NumPads-1:0] pad_d_i,

    output logic               busy_o
);

    // Elaboration-time guard on the parameter ranges the timing relies on.
    if (TurnCycles < 1) begin : gen_bad_turn_cycles
        $error("mc_pad_io_ctrl: TurnCycles must be >= 1");
    end
    if (SyncStages < 2) begin : gen_bad_sync_stages
        $error("mc_pad_io_ctrl: SyncStages must be >= 2");
    end

    // The turnaround counter only has to reach TurnCycles-1; sizing it for
    // TurnCycles+1 values keeps it at least one bit wide when TurnCycles is 1.
    localparam int TurnW = $clog2(TurnCycles + 1);
    localparam logic [TurnW-1:0] TurnLast = TurnW'(TurnCycles - 1);

    padState_e         state_q;
    logic              padOe_q;
    logic [NumPads-1:0] padD_q;
    logic              rspValid_q;
    logic [NumPads-1:0] rspData_q;
    logic [NumPads-1:0] wrData_q;
    logic              wrPending_q;
    logic [TurnW-1:0]  turnCnt_q;

    // Value that a read captures: the synchronizer output or the raw pads.
    logic [NumPads-1:0] sampleData;

`ifdef MC_PAD_IO_CTRL_SYNC_EN
    localparam int SettleW = $clog2(SyncStages + 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SyncStages - 1);

    logic [SettleW-1:0] settleCnt_q;

    mc_pad_sync #(
        .Width (NumPads),
        .Depth (SyncStages)
    ) u_pad_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pad_d_i),
        .q_o   (sampleData)
    );
`else
    assign sampleData = pad_d_i;
`endif

    // Main controller: state, pad drive, response channel and counters all
    // live in this one registered process so every output is a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RX_IDLE;
            padOe_q     <= 1'b0;
            padD_q      <= '0;
            rspValid_q  <= 1'b0;
            rspData_q   <= '0;
            wrData_q    <= '0;
            wrPending_q <= 1'b0;
            turnCnt_q   <= '0;
`ifdef MC_PAD_IO_CTRL_SYNC_EN
            settleCnt_q <= '0;
`endif
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (req_valid_i) begin
                        if (req_write_i) begin
                            // Pads are released: hold the data until the
                            // dead time has passed, then drive it.
                            wrData_q    <= req_data_i;
                            wrPending_q <= 1'b1;
                            turnCnt_q   <= '0;
                            state_q     <= TURN;
                        end else begin
`ifdef MC_PAD_IO_CTRL_SYNC_EN
                            settleCnt_q <= '0;
                            state_q     <= SETTLE;
`else
                            rspData_q   <= sampleData;
                            rspValid_q  <= 1'b1;
                            state_q     <= RESP;
`endif
                        end
                    end
                end

                TX_IDLE: begin
                    if (req_valid_i) begin
                        if (req_write_i) begin
                            // Already driving: just update the pad value.
                            padD_q <= req_data_i;
                        end else begin
                            // Release the bus first, then wait out the
                            // dead time before looking at the pads.
                            padOe_q     <= 1'b0;
                            wrPending_q <= 1'b0;
                            turnCnt_q   <= '0;
                            state_q     <= TURN;
                        end
                    end
                end

                TURN: begin
                    if (turnCnt_q == TurnLast) begin
                        turnCnt_q <= '0;
                        if (wrPending_q) begin
                            // Output enable and the new data go live together.
                            padOe_q     <= 1'b1;
                            padD_q      <= wrData_q;
                            wrPending_q <= 1'b0;
                            state_q     <= TX_IDLE;
                        end else begin
`ifdef MC_PAD_IO_CTRL_SYNC_EN
                            settleCnt_q <= '0;
                            state_q     <= SETTLE;
`else
                            rspData_q   <= sampleData;
                            rspValid_q  <= 1'b1;
                            state_q     <= RESP;
`endif
                        end
                    end else begin
                        turnCnt_q <= turnCnt_q + TurnW'(1);
                    end
                end

`ifdef MC_PAD_IO_CTRL_SYNC_EN
                SETTLE: begin
                    // Give the synchronizer time to flush values that were
                    // on the pads before they were released.
                    if (settleCnt_q == SettleLast) begin
                        settleCnt_q <= '0;
                        rspData_q   <= sampleData;
                        rspValid_q  <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        settleCnt_q <= settleCnt_q + SettleW'(1);
                    end
                end
`endif

                RESP: begin
                    // Hold the captured value until the consumer takes it;
                    // the completing cycle does not accept a new request.
                    if (rsp_ready_i) begin
                        rspValid_q <= 1'b0;
                        state_q    <= RX_IDLE;
                    end
                end

                default: begin
                    padOe_q     <= 1'b0;
                    rspValid_q  <= 1'b0;
                    wrPending_q <= 1'b0;
                    turnCnt_q   <= '0;
                    state_q     <= RX_IDLE;
                end
            endcase
        end
    end

    // Requests are only taken while idle, in either drive direction.
    assign req_ready_o = (state_q == RX_IDLE) || (state_q == TX_IDLE);
    assign busy_o      = !req_ready_o;

    assign rsp_valid_o = rspValid_q;
    assign rsp_data_o  = rspData_q;
    assign pad_d_o     = padD_q;
    assign pad_oe_o    = padOe_q;

endmodule : mc_pad_io_ctrl

// File: tb/tb_mc_pad_io_ctrl.sv
// tb_mc_pad_io_ctrl -- directed self-checking bench for mc_pad_io_ctrl.
// Runs with the default parameters (8 pads, 2 turn cycles, 2 sync stages).
// Read latencies adapt to whether MC_PAD_IO_CTRL_SYNC_EN is defined.

module tb_mc_pad_io_ctrl;

    localparam int NumPads    = 8;
    localparam int TurnCycles = 2;
    localparam int SyncStages = 2;

`ifdef MC_PAD_IO_CTRL_SYNC_EN
    localparam int ReadLatRx = SyncStages + 1;
    localparam int ReadLatTx = TurnCycles + SyncStages + 1;
`else
    localparam int ReadLatRx = 1;
    localparam int ReadLatTx = TurnCycles + 1;
`endif

    logic               clk_i;
    logic               rst_i;
    logic               req_valid_i;
    logic               req_ready_o;
    logic               req_write_i;
    logic [NumPads-1:0] req_data_i;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [NumPads-1:0] rsp_data_o;
    logic [NumPads-1:0] pad_d_o;
    logic               pad_oe_o;
    logic [NumPads-1:0] pad_d_i;
    logic               busy_o;

    int testsRun;
    int testsFailed;
    int lat;
    int oeHigh;
    int seen;

    mc_pad_io_ctrl #(
        .NumPads    (NumPads),
        .TurnCycles (TurnCycles),
        .SyncStages (SyncStages)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_data_i  (req_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .pad_d_o     (pad_d_o),
        .pad_oe_o    (pad_oe_o),
        .pad_d_i     (pad_d_i),
        .busy_o      (busy_o)
    );

    // Free-running 10 ns clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive the request channel.
    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [NumPads-1:0] data);
        req_valid_i = valid;
        req_write_i = write;
        req_data_i  = data;
    endtask

    // Compare an 8-bit bus value.
    task automatic checkOutput(input string tag, input logic [NumPads-1:0] observed,
                               input logic [NumPads-1:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Compare a single-bit signal.
    task automatic checkBit(input string tag, input logic observed, input logic expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Compare a measured count.
    task automatic checkCount(input string tag, input int observed, input int expected);
        testsRun++;
        assert (observed == expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Called in the first cycle after a read handshake: counts cycles until
    // rsp_valid_o rises (bounded), and how many of them had pad_oe_o high.
    task automatic waitRsp(output int latency, output int oeCount);
        latency = 1;
        oeCount = 0;
        while (!rsp_valid_o && latency < 40) begin
            if (pad_oe_o) oeCount++;
            tick();
            latency++;
        end
        if (pad_oe_o) oeCount++;
        if (!rsp_valid_o) latency = -1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_i       = 1'b1;
        rsp_ready_i = 1'b0;
        pad_d_i     = '0;
        applyStimulus(1'b0, 1'b0, '0);

        // Reset values.
        tick();
        tick();
        checkBit("rst_pad_oe", pad_oe_o, 1'b0);
        checkOutput("rst_pad_d", pad_d_o, 8'h00);
        checkBit("rst_rsp_valid", rsp_valid_o, 1'b0);
        checkOutput("rst_rsp_data", rsp_data_o, 8'h00);
        rst_i = 1'b0;
        checkBit("rst_ready_after", req_ready_o, 1'b1);
        checkBit("rst_busy_after", busy_o, 1'b0);

        // Write 0xA5 from RX_IDLE: two dead cycles, then drive at +3.
        applyStimulus(1'b1, 1'b1, 8'hA5);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkBit("wr_rx_oe_c1", pad_oe_o, 1'b0);
        checkBit("wr_rx_busy_c1", busy_o, 1'b1);
        checkBit("wr_rx_ready_c1", req_ready_o, 1'b0);
        tick();
        checkBit("wr_rx_oe_c2", pad_oe_o, 1'b0);
        checkOutput("wr_rx_pad_d_c2", pad_d_o, 8'h00);
        tick();
        checkBit("wr_rx_oe_c3", pad_oe_o, 1'b1);
        checkOutput("wr_rx_pad_d_c3", pad_d_o, 8'hA5);
        checkBit("wr_rx_ready_c3", req_ready_o, 1'b1);

        // Write 0x3C while driving, then read 0x5A from TX_IDLE.
        applyStimulus(1'b1, 1'b1, 8'h3C);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("wr_tx_pad_d", pad_d_o, 8'h3C);
        checkBit("wr_tx_oe", pad_oe_o, 1'b1);
        checkBit("wr_tx_no_rsp", rsp_valid_o, 1'b0);
        pad_d_i = 8'h5A;
        applyStimulus(1'b1, 1'b0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkBit("rd_tx_oe_c1", pad_oe_o, 1'b0);
        checkOutput("rd_tx_pad_d_hold", pad_d_o, 8'h3C);
        waitRsp(lat, oeHigh);
        checkCount("rd_tx_latency", lat, ReadLatTx);
        checkCount("rd_tx_oe_high", oeHigh, 0);
        checkOutput("rd_tx_data", rsp_data_o, 8'h5A);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        checkBit("rd_tx_valid_drop", rsp_valid_o, 1'b0);
        checkBit("rd_tx_ready_back", req_ready_o, 1'b1);

        // Read 0xC3 from RX_IDLE with the consumer stalling 4 cycles.
        pad_d_i = 8'hC3;
        applyStimulus(1'b1, 1'b0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        waitRsp(lat, oeHigh);
        checkCount("rd_rx_latency", lat, ReadLatRx);
        checkOutput("rd_rx_data", rsp_data_o, 8'hC3);
        checkBit("rd_rx_ready_resp", req_ready_o, 1'b0);
        pad_d_i = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkBit("rd_rx_stall_valid", rsp_valid_o, 1'b1);
            checkOutput("rd_rx_stall_data", rsp_data_o, 8'hC3);
            checkBit("rd_rx_stall_ready", req_ready_o, 1'b0);
        end
        // Offer a write in the completing cycle: it must not be taken.
        rsp_ready_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'h99);
        checkBit("resp_done_ready", req_ready_o, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        rsp_ready_i = 1'b0;
        checkBit("resp_done_valid", rsp_valid_o, 1'b0);
        checkBit("resp_done_no_accept", busy_o, 1'b0);
        checkBit("resp_done_ready_back", req_ready_o, 1'b1);

        // Drive 0x77, read from TX_IDLE, and reset during TURN.
        applyStimulus(1'b1, 1'b1, 8'h77);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        tick();
        tick();
        checkOutput("pre_rst_pad_d", pad_d_o, 8'h77);
        checkBit("pre_rst_oe", pad_oe_o, 1'b1);
        applyStimulus(1'b1, 1'b0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkBit("pre_rst_in_turn", busy_o, 1'b1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checkBit("mid_rst_oe", pad_oe_o, 1'b0);
        checkOutput("mid_rst_pad_d", pad_d_o, 8'h00);
        checkBit("mid_rst_ready", req_ready_o, 1'b1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid_o) seen++;
            tick();
        end
        checkCount("mid_rst_no_rsp", seen, 0);

        // Enter TX_IDLE with 0x10, then back-to-back writes 0x01..0x03.
        applyStimulus(1'b1, 1'b1, 8'h10);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        tick();
        tick();
        checkOutput("b2b_start_pad_d", pad_d_o, 8'h10);
        oeHigh = 0;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(i));
            tick();
            if (pad_oe_o) oeHigh++;
            checkOutput("b2b_pad_d", pad_d_o, 8'(i));
        end
        applyStimulus(1'b0, 1'b0, '0);
        checkCount("b2b_oe_held", oeHigh, 3);
        tick();
        checkBit("b2b_no_rsp", rsp_valid_o, 1'b0);
        checkBit("b2b_idle_ready", req_ready_o, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_mc_pad_io_ctrl

// File: doc/mc_pad_io_ctrl.md
MC_PAD_IO_CTRL -- requirements
Module: mc_pad_io_ctrl

Interface
REQ-001 SHALL have parameter NumPads, default 8: width of the bidirectional pad bank.
REQ-002 SHALL have parameter TurnCycles, default 2, legal range >=1: bus dead cycles inserted on every drive-direction change.
REQ-003 SHALL have parameter SyncStages, default 2, legal range >=2: input synchronizer depth.
REQ-004 SHALL have port clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid_i, input, 1: request valid.
REQ-007 SHALL have port req_ready_o, output, 1: request accepted when req_valid_i and req_ready_o are both high.
REQ-008 SHALL have port req_write_i, input, 1: 1 = drive bus, 0 = sample bus.
REQ-009 SHALL have port req_data_i, input, NumPads: value to drive.
REQ-010 SHALL have port rsp_valid_o, output, 1: read data valid.
REQ-011 SHALL have port rsp_ready_i, input, 1: read data consumed.
REQ-012 SHALL have port rsp_data_o, output, NumPads: sampled bus value.
REQ-013 SHALL have port pad_d_o, output, NumPads: to pad-cell data input.
REQ-014 SHALL have port pad_oe_o, output, 1: to pad-cell output enable, active-high, common to all pads.
REQ-015 SHALL have port pad_d_i, input, NumPads: from pad-cell data output, asynchronous.
REQ-016 SHALL have port busy_o, output, 1: high in any state other than RX_IDLE and TX_IDLE.

Function
REQ-017 SHALL implement FSM states RX_IDLE (released), TX_IDLE (driving), TURN, SETTLE and RESP.
REQ-018 SHALL assert req_ready_o only in RX_IDLE and TX_IDLE.
REQ-019 On a write in TX_IDLE, SHALL update pad_d_o on the next edge, keep pad_oe_o high and remain in TX_IDLE.
REQ-020 On a write in RX_IDLE, SHALL register req_data_i, spend TurnCycles cycles in TURN with pad_oe_o low, then assert pad_oe_o together with the new pad_d_o exactly TurnCycles+1 cycles after the handshake, and enter TX_IDLE.
REQ-021 On a read in TX_IDLE, SHALL deassert pad_oe_o on the next edge, spend TurnCycles cycles in TURN, then SyncStages cycles in SETTLE, then capture into rsp_data_o and enter RESP; rsp_valid_o rises TurnCycles+SyncStages+1 cycles after the handshake.
REQ-022 On a read in RX_IDLE, SHALL skip TURN; rsp_valid_o rises SyncStages+1 cycles after the handshake.
REQ-023 In RESP, SHALL hold rsp_valid_o high and rsp_data_o stable until rsp_ready_i is high, then return to RX_IDLE on the next edge.
REQ-024 SHALL not accept a new request in the cycle in which RESP completes.
REQ-025 Writes SHALL produce no response.
REQ-026 SHALL never assert pad_oe_o in TURN, SETTLE or RESP.
REQ-027 SHALL keep pad_d_o unchanged while pad_oe_o is low, except when loading registered write data.
REQ-028 SHALL use a TurnCycles counter sized $clog2(TurnCycles+1) and a SETTLE counter sized $clog2(SyncStages+1); both SHALL clear on every state entry, with no wrap-around.

Reset
REQ-029 While rst_i is high at an edge, SHALL set the state to RX_IDLE, pad_oe_o=0, pad_d_o=0, rsp_valid_o=0, rsp_data_o=0, counters=0, synchronizer flops=0.
REQ-030 Reset asserted mid-operation in any state SHALL drop pad_oe_o at that edge; any in-flight request SHALL be discarded with no response.
REQ-031 req_ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Configuration
REQ-032 With macro MC_PAD_IO_CTRL_SYNC_EN defined, SHALL pass pad_d_i through SyncStages flops before capture and use SETTLE as specified.
REQ-033 Without MC_PAD_IO_CTRL_SYNC_EN, SHALL sample pad_d_i directly, omit SETTLE and ignore SyncStages; read latency becomes 1 cycle from RX_IDLE and TurnCycles+1 cycles from TX_IDLE.

Structure
REQ-034 SHALL place the state enum type and parameter defaults (NumPads, TurnCycles, SyncStages) in package mc_pad_ctrl_pkg.
REQ-035 SHALL instantiate sub-module mc_pad_sync (parameterized width and depth, synchronous active-high reset) for the input synchronizer, present only under MC_PAD_IO_CTRL_SYNC_EN.

Verification (NumPads=8, TurnCycles=2, SyncStages=2, SYNC_EN defined)
REQ-036 Write 0xA5 from RX_IDLE -> pad_oe_o=0 for 2 cycles, then pad_oe_o=1 and pad_d_o=0xA5 at handshake+3.
REQ-037 Write 0x3C in TX_IDLE, then a read with pad_d_i=0x5A -> pad_oe_o falls at +1; rsp_valid_o at +5 with rsp_data_o=0x5A.
REQ-038 Read from RX_IDLE with rsp_ready_i held low for 4 cycles -> rsp_valid_o at +3, rsp_data_o stable, req_ready_o=0 until the return to RX_IDLE.
REQ-039 Assert rst_i during TURN after a read -> pad_oe_o=0, rsp_valid_o never rises, req_ready_o=1 the cycle after reset releases.
REQ-040 Back-to-back writes 0x01, 0x02, 0x03 in TX_IDLE -> pad_d_o follows one cycle later each time, pad_oe_o never drops.
REQ-041 Rebuild without SYNC_EN; read from RX_IDLE -> rsp_valid_o at handshake+1.
